// File: rtl/fpa_pkg.sv
// rtl/fpa_pkg.sv - shared widths, constants and stage payload for the fpa normaliser
package fpa_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 5;
  localparam int LZ_W   = 5;

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam int               EXP_BIAS = 127;
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  // Bit positions inside the incoming mantissa
  localparam int M_CARRY   = 27;
  localparam int M_HIDDEN  = 26;
  localparam int M_FRAC_HI = 25;
  localparam int M_FRAC_LO = 3;
  localparam int M_G       = 2;
  localparam int M_R       = 1;
  localparam int M_S       = 0;

  typedef struct packed {
    logic ovf;
    logic unf;
  } flags_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W+1:0]  exp;
    logic [MANT_W-1:0] mantis;
    flags_t            flags;
    logic              special;
  } stage_t;

  function automatic logic [31:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                          input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fpa_lzc.sv
// rtl/fpa_lzc.sv - leading-zero counter over hidden bit and fraction/GRS field
module fpa_lzc
  import fpa_pkg::*;
(
  input  logic [MANT_W-2:0] i_data,
  output logic [LZ_W-1:0]   o_count
);

  // Highest set bit wins because it is visited last
  always_comb begin
    o_count = LZ_W'(MANT_W - 1);
    for (int i = 0; i < MANT_W - 1; i++) begin
      if (i_data[i]) o_count = LZ_W'(MANT_W - 2 - i);
    end
  end

endmodule

// File: rtl/fpa_normalizer.sv
// rtl/fpa_normalizer.sv - 3-stage normalise/round/pack pipeline for the fpa adder sum
module fpa_normalizer
  import fpa_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_sign,
  input  logic [EXP_W-1:0]  i_in_exp,
  input  logic [MANT_W-1:0] i_in_mantis,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_result,
  output logic              o_out_ovf,
  output logic              o_out_unf,
  output logic              o_out_inexact
);

  logic              w_advance;
  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [MANT_W-1:0] r_s1_mantis;
  logic [LZ_W-1:0]   w_lz;

  logic                    w_s2_special;
  logic signed [EXP_W+1:0] w_exp_in;
  logic signed [EXP_W+1:0] w_exp_norm;
  logic [MANT_W-1:0]       w_mant_norm;
  stage_t                  w_s2;
  stage_t                  r_s2;
  logic                    r_s2_valid;

  logic                    w_inc;
  logic                    w_carry;
  logic                    w_grs;
  logic [FRAC_W:0]         w_frac_sum;
  logic signed [EXP_W+1:0] w_exp_rnd;
  logic [31:0]             w_result;
  logic                    w_ovf;
  logic                    w_unf;
  logic                    w_inexact;

  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic        r_out_ovf;
  logic        r_out_unf;
  logic        r_out_inexact;

  assign w_advance  = !r_out_valid || i_out_ready;
  assign o_in_ready = w_advance;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid  <= i_in_valid;
      r_s1_sign   <= i_in_sign;
      r_s1_exp    <= i_in_exp;
      r_s1_mantis <= i_in_mantis;
    end
  end

  fpa_lzc u_lzc (
    .i_data  (r_s1_mantis[MANT_W-2:0]),
    .o_count (w_lz)
  );

  // Exponent is widened by two signed bits so large left shifts go negative instead of wrapping
  always_comb begin
    w_exp_in    = $signed({2'b00, r_s1_exp});
    w_exp_norm  = w_exp_in;
    w_mant_norm = r_s1_mantis;
    if (r_s1_mantis[M_CARRY]) begin
      w_mant_norm = {1'b0, r_s1_mantis[MANT_W-1:2], r_s1_mantis[M_R] | r_s1_mantis[M_S]};
      w_exp_norm  = w_exp_in + 10'sd1;
    end else if (!r_s1_mantis[M_HIDDEN]) begin
      w_mant_norm = r_s1_mantis << w_lz;
      w_exp_norm  = w_exp_in - $signed({5'b00000, w_lz});
    end
    w_s2_special    = (r_s1_exp == EXP_MAX);
    w_s2.sign       = r_s1_sign;
    w_s2.special    = w_s2_special;
    w_s2.exp        = w_exp_norm;
    w_s2.mantis     = w_s2_special ? r_s1_mantis : w_mant_norm;
    w_s2.flags.unf  = !w_s2_special && (w_exp_norm <= 0);
    w_s2.flags.ovf  = !w_s2_special && (w_exp_norm >= 255);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_valid <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2       <= w_s2;
    end
  end

  always_comb begin
    w_inc      = r_s2.mantis[M_G] &&
                 (r_s2.mantis[M_R] || r_s2.mantis[M_S] || r_s2.mantis[M_FRAC_LO]);
    w_grs      = |r_s2.mantis[M_G:M_S];
    w_frac_sum = {1'b0, r_s2.mantis[M_FRAC_HI:M_FRAC_LO]} + (FRAC_W+1)'(w_inc);
    w_carry    = w_frac_sum[FRAC_W];
    w_exp_rnd  = $signed(r_s2.exp) + $signed({{(EXP_W+1){1'b0}}, w_carry});
    w_result   = pack_fp(r_s2.sign, w_exp_rnd[EXP_W-1:0], w_frac_sum[FRAC_W-1:0]);
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    w_inexact  = w_grs;
    if (r_s2.special) begin
      w_result  = (r_s2.mantis[M_FRAC_HI:M_FRAC_LO] == '0) ? pack_fp(r_s2.sign, EXP_MAX, '0) : QNAN;
      w_inexact = 1'b0;
    end else if (r_s2.mantis == '0) begin
      w_result  = '0;
      w_inexact = 1'b0;
    end else if (r_s2.flags.unf) begin
      w_result  = {r_s2.sign, 31'b0};
      w_unf     = 1'b1;
      w_inexact = 1'b1;
    end else if (r_s2.flags.ovf || (w_exp_rnd >= 255)) begin
      w_result  = pack_fp(r_s2.sign, EXP_MAX, '0);
      w_ovf     = 1'b1;
      w_inexact = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_ovf     <= 1'b0;
      r_out_unf     <= 1'b0;
      r_out_inexact <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_result  <= w_result;
        r_out_ovf     <= w_ovf;
        r_out_unf     <= w_unf;
        r_out_inexact <= w_inexact;
      end
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_result  = r_out_result;
  assign o_out_ovf     = r_out_ovf;
  assign o_out_unf     = r_out_unf;
  assign o_out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fpa_normalizer.sv
// tb/tb_fpa_normalizer.sv - scoreboard bench for fpa_normalizer with directed and random traffic
module tb_fpa_normalizer;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [34:0] r;
  } vec_t;

  logic        clk = 1'b0;
  logic        i_rst, i_in_valid, i_in_sign, i_out_ready;
  logic [7:0]  i_in_exp;
  logic [27:0] i_in_mantis;
  logic        o_in_ready, o_out_valid, o_out_ovf, o_out_unf, o_out_inexact;
  logic [31:0] o_out_result;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_in = 0;
  int          n_out = 0;
  logic [34:0] exp_q[$];
  logic        dir_pending = 1'b0;
  logic [34:0] dir_exp = '0;
  logic        held_valid = 1'b0;
  logic [34:0] held_val, mon_cur, mon_exp;
  vec_t        dvec[16];
  logic        rnd_done;
  logic        r_s;
  logic [7:0]  r_e;
  logic [27:0] r_m;
  longint      mask;
  int          lat;

  always #5 clk = ~clk;

  fpa_normalizer dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_sign     (i_in_sign),
    .i_in_exp      (i_in_exp),
    .i_in_mantis   (i_in_mantis),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_result  (o_out_result),
    .o_out_ovf     (o_out_ovf),
    .o_out_unf     (o_out_unf),
    .o_out_inexact (o_out_inexact)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value-level model: locate the MSB, keep 24 significant bits, round on the remainder
  function automatic logic [34:0] ref_model(input logic s, input logic [7:0] e, input logic [27:0] m);
    longint mant, keep, rem, half;
    int     p, ee;
    mant = longint'(m);
    if (e == 8'hFF) begin
      if (m[25:3] == 23'd0) return {s, 8'hFF, 23'd0, 3'b000};
      return {32'h7FC00000, 3'b000};
    end
    if (m == 28'd0) return 35'd0;
    p = 27;
    while (m[p] == 1'b0) p--;
    ee = int'(e) + p - 26;
    if (ee <= 0) return {s, 31'd0, 3'b011};
    rem = 0;
    if (p > 23) begin
      keep = mant >> (p - 23);
      rem  = mant & ((64'sd1 << (p - 23)) - 1);
      half = 64'sd1 << (p - 24);
      if (rem > half || (rem == half && keep[0])) keep++;
    end else begin
      keep = mant << (23 - p);
    end
    if (keep == (64'sd1 << 24)) begin
      keep = keep >> 1;
      ee++;
    end
    if (ee >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    return {s, 8'(ee), 23'(keep), 2'b00, rem != 0};
  endfunction

  always @(negedge clk) begin
    if (i_rst) begin
      exp_q.delete();
      held_valid = 1'b0;
      n_in = 0;
      n_out = 0;
    end else begin
      mon_cur = {o_out_result, o_out_ovf, o_out_unf, o_out_inexact};
      if (held_valid) begin
        check("out_valid_held", 64'(o_out_valid), 64'd1);
        check("out_stable", 64'(mon_cur), 64'(held_val));
      end
      if (o_out_valid && !i_out_ready) check("in_ready_stall", 64'(o_in_ready), 64'd0);
      held_valid = o_out_valid && !i_out_ready;
      held_val   = mon_cur;
      if (i_in_valid && o_in_ready) begin
        exp_q.push_back(dir_pending ? dir_exp : ref_model(i_in_sign, i_in_exp, i_in_mantis));
        n_in++;
      end
      if (o_out_valid && i_out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", 64'(mon_cur[34:3]), 64'(mon_exp[34:3]));
          check("flags", 64'(mon_cur[2:0]), 64'(mon_exp[2:0]));
        end
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m);
    int n = 0;
    i_in_valid  = 1'b1;
    i_in_sign   = s;
    i_in_exp    = e;
    i_in_mantis = m;
    @(negedge clk);
    while (!o_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", 64'(n < 100), 64'd1);
    @(posedge clk);
    #1 i_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic rand_op();
    int k;
    k     = $urandom_range(1, 28);
    mask  = (64'sd1 << k) - 1;
    r_m   = 28'(longint'($urandom) & mask);
    if ($urandom_range(0, 5) == 0) r_m[2:0] = 3'b100;
    case ($urandom_range(0, 4))
      0:       r_e = 8'hFF;
      1:       r_e = 8'($urandom_range(0, 30));
      2:       r_e = 8'($urandom_range(225, 254));
      default: r_e = 8'($urandom_range(1, 254));
    endcase
    r_s = 1'($urandom_range(0, 1));
    send(r_s, r_e, r_m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    dvec[0]  = '{1'b0, 8'd127, 28'h8000000, {32'h40000000, 3'b000}};
    dvec[1]  = '{1'b0, 8'd127, 28'h4000004, {32'h3F800000, 3'b001}};
    dvec[2]  = '{1'b0, 8'd127, 28'h400000C, {32'h3F800002, 3'b001}};
    dvec[3]  = '{1'b0, 8'd127, 28'h0000008, {32'h34000000, 3'b000}};
    dvec[4]  = '{1'b0, 8'd127, 28'h0000000, {32'h00000000, 3'b000}};
    dvec[5]  = '{1'b0, 8'd254, 28'h8000000, {32'h7F800000, 3'b101}};
    dvec[6]  = '{1'b1, 8'd3,   28'h0000008, {32'h80000000, 3'b011}};
    dvec[7]  = '{1'b0, 8'hFF,  28'h4000007, {32'h7F800000, 3'b000}};
    dvec[8]  = '{1'b1, 8'hFF,  28'h4000008, {32'h7FC00000, 3'b000}};
    dvec[9]  = '{1'b1, 8'd127, 28'h0000000, {32'h00000000, 3'b000}};
    dvec[10] = '{1'b0, 8'd127, 28'h7FFFFFC, {32'h40000000, 3'b001}};
    dvec[11] = '{1'b0, 8'd254, 28'h7FFFFFC, {32'h7F800000, 3'b101}};
    dvec[12] = '{1'b0, 8'd1,   28'h4000000, {32'h00800000, 3'b000}};
    dvec[13] = '{1'b0, 8'd0,   28'h4000000, {32'h00000000, 3'b011}};
    dvec[14] = '{1'b1, 8'd127, 28'hC000001, {32'hC0400000, 3'b001}};
    dvec[15] = '{1'b1, 8'hFF,  28'h0000000, {32'hFF800000, 3'b000}};

    i_rst = 1'b1; i_in_valid = 1'b0; i_in_sign = 1'b0; i_in_exp = '0; i_in_mantis = '0;
    i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(o_out_valid), 64'd0);
    check("rst_out_result", 64'(o_out_result), 64'd0);
    check("rst_flags", 64'({o_out_ovf, o_out_unf, o_out_inexact}), 64'd0);
    check("rst_in_ready", 64'(o_in_ready), 64'd1);
    i_rst = 1'b0;

    // Single op into an empty pipe: result must be visible right after the third edge
    @(posedge clk);
    #1;
    dir_pending = 1'b1; dir_exp = dvec[0].r;
    i_in_valid = 1'b1; i_in_sign = dvec[0].s; i_in_exp = dvec[0].e; i_in_mantis = dvec[0].m;
    @(posedge clk);
    lat = 1;
    #1 i_in_valid = 1'b0; dir_pending = 1'b0;
    while (!o_out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("latency", 64'(lat), 64'd3);
    drain();

    for (int i = 0; i < 16; i++) begin
      dir_exp = dvec[i].r;
      dir_pending = 1'b1;
      send(dvec[i].s, dvec[i].e, dvec[i].m);
      dir_pending = 1'b0;
    end
    drain();

    i_out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) rand_op();
      end
      begin
        int n = 0;
        while (!o_out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("bp_fill", 64'(o_out_valid), 64'd1);
        repeat (4) @(posedge clk);
        #1 i_out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(n_out), 64'(n_in));

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) rand_op();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 i_out_ready = ($urandom_range(0, 3) != 0);
        end
        i_out_ready = 1'b1;
      end
    join
    drain();
    check("rand_count", 64'(n_out), 64'(n_in));

    for (int i = 0; i < 4; i++) rand_op();
    check("pre_rst_valid", 64'(o_out_valid), 64'd1);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(o_out_valid), 64'd0);
    check("midrst_out_result", 64'(o_out_result), 64'd0);
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("midrst_flushed", 64'(o_out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
